bram_frame_streamer: RTL and testbench

//  Streams one full lattice frame (DEPTH cells x NUM_DIRS distribution values) from the

---
 rtl/bram_frame_streamer.sv | 128 ++++++++++++
 tb/tb_bram_frame_streamer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_frame_streamer.sv
// Streams one lattice frame from the LBM BRAM bank to an AXI4-Stream DMA.
// Credit-limited prefetch keeps reads ahead of the stream without overrunning the FIFO.
module bram_frame_streamer #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_DIRS   = 9,
    parameter int DEPTH      = 2500,
    parameter int ADDR_WIDTH = 12,
    parameter int RD_LATENCY = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                               m00_axis_aclk,
    input  logic                               m00_axis_aresetn,
    input  logic                               frame_ready,
    output logic                               rd_en,
    output logic [ADDR_WIDTH-1:0]              rd_addr,
    input  logic [NUM_DIRS*DATA_WIDTH-1:0]     rd_data,
    input  logic                               m00_axis_tready,
    output logic                               m00_axis_tvalid,
    output logic [NUM_DIRS*DATA_WIDTH-1:0]     m00_axis_tdata,
    output logic [NUM_DIRS*DATA_WIDTH/8-1:0]   m00_axis_tstrb,
    output logic                               m00_axis_tlast,
    output logic                               busy,
    output logic                               frame_done
);

    localparam int W  = NUM_DIRS * DATA_WIDTH;
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1) + 1;

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

    state_t                 state, next_state;
    logic [ADDR_WIDTH-1:0]  issue_cnt;
    logic                   issue, issue_last, rd_last;
    logic [RD_LATENCY-1:0]  vpipe, lpipe;
    logic [W-1:0]           mem [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0]  last_mem;
    logic [PW-1:0]          wptr, rptr;
    logic [CW-1:0]          count, used;
    logic                   push, pop;

    assign issue_last = (issue_cnt == ADDR_WIDTH'(DEPTH - 1));
    assign push       = vpipe[RD_LATENCY-1];
    assign pop        = m00_axis_tvalid && m00_axis_tready;

    // FIFO slots already claimed: stored entries plus every read still in flight
    always_comb begin
        used = count + CW'(rd_en);
        for (int i = 0; i < RD_LATENCY; i++)
            used = used + CW'(vpipe[i]);
    end

    always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
        if (!m00_axis_aresetn) state <= IDLE;
        else                   state <= next_state;
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:  if (frame_ready) next_state = READ;
            READ:  if (issue && issue_last) next_state = DRAIN;
            DRAIN: if (pop && m00_axis_tlast) next_state = DONE;
            DONE:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        busy       = (state != IDLE);
        frame_done = (state == DONE);
        issue      = (state == READ) && (used < CW'(FIFO_DEPTH));
    end

    always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
        if (!m00_axis_aresetn) begin
            rd_en     <= 1'b0;
            rd_addr   <= '0;
            rd_last   <= 1'b0;
            issue_cnt <= '0;
            vpipe     <= '0;
            lpipe     <= '0;
        end else begin
            rd_en   <= issue;
            rd_last <= issue && issue_last;
            if (issue) begin
                rd_addr   <= issue_cnt;
                issue_cnt <= issue_cnt + ADDR_WIDTH'(1);
            end
            if (state == DONE) begin
                rd_addr   <= '0;
                issue_cnt <= '0;
            end
            vpipe[0] <= rd_en;
            lpipe[0] <= rd_last;
            for (int i = 1; i < RD_LATENCY; i++) begin
                vpipe[i] <= vpipe[i-1];
                lpipe[i] <= lpipe[i-1];
            end
        end
    end

    always_ff @(posedge m00_axis_aclk) begin
        if (push) mem[wptr] <= rd_data;
    end

    always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
        if (!m00_axis_aresetn) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            last_mem <= '0;
        end else begin
            if (push) begin
                last_mem[wptr] <= lpipe[RD_LATENCY-1];
                wptr           <= wptr + PW'(1);
            end
            if (pop) rptr <= rptr + PW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    assign m00_axis_tvalid = (count != '0);
    assign m00_axis_tdata  = m00_axis_tvalid ? mem[rptr] : '0;
    assign m00_axis_tlast  = m00_axis_tvalid && last_mem[rptr];
    assign m00_axis_tstrb  = '1;

endmodule

// File: tb/tb_bram_frame_streamer.sv
// Bench for bram_frame_streamer: short-frame/latency-1 and latency-3 instances
// fed by behavioural BRAM models with an address-derived data pattern.
module tb_bram_frame_streamer;

    logic          clk = 1'b0;
    logic          rst0, rst1, fr0, fr1, tr0, tr1;
    logic          rd_en0, rd_en1, tv0, tv1, tl0, tl1;
    logic          busy0, busy1, done0, done1;
    logic [3:0]    rd_addr0;
    logic [4:0]    rd_addr1;
    logic [143:0]  rd_data0, td0;
    logic [15:0]   rd_data1, td1;
    logic [17:0]   ts0;
    logic [1:0]    ts1;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    bram_frame_streamer #(
        .DATA_WIDTH(16), .NUM_DIRS(9), .DEPTH(8), .ADDR_WIDTH(4),
        .RD_LATENCY(1), .FIFO_DEPTH(4)
    ) u0 (
        .m00_axis_aclk(clk), .m00_axis_aresetn(rst0), .frame_ready(fr0),
        .rd_en(rd_en0), .rd_addr(rd_addr0), .rd_data(rd_data0),
        .m00_axis_tready(tr0), .m00_axis_tvalid(tv0), .m00_axis_tdata(td0),
        .m00_axis_tstrb(ts0), .m00_axis_tlast(tl0),
        .busy(busy0), .frame_done(done0)
    );

    bram_frame_streamer #(
        .DATA_WIDTH(8), .NUM_DIRS(2), .DEPTH(16), .ADDR_WIDTH(5),
        .RD_LATENCY(3), .FIFO_DEPTH(8)
    ) u1 (
        .m00_axis_aclk(clk), .m00_axis_aresetn(rst1), .frame_ready(fr1),
        .rd_en(rd_en1), .rd_addr(rd_addr1), .rd_data(rd_data1),
        .m00_axis_tready(tr1), .m00_axis_tvalid(tv1), .m00_axis_tdata(td1),
        .m00_axis_tstrb(ts1), .m00_axis_tlast(tl1),
        .busy(busy1), .frame_done(done1)
    );

    function automatic logic [143:0] pat0(input int a);
        logic [143:0] r;
        for (int d = 0; d < 9; d++) r[143-16*d -: 16] = {8'(a), 8'(d)};
        return r;
    endfunction

    function automatic logic [15:0] pat1(input int a);
        return {8'(a), ~8'(a)};
    endfunction

    // BRAM models: latency 1 for u0, latency 3 for u1
    logic [15:0] s1, s2;
    always @(posedge clk) begin
        rd_data0 <= rd_en0 ? pat0(int'(rd_addr0)) : {9{16'hDEAD}};
        s1       <= rd_en1 ? pat1(int'(rd_addr1)) : 16'hDEAD;
        s2       <= s1;
        rd_data1 <= s2;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [143:0] act,
                       input logic [143:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    typedef struct {
        bit busy; bit rden; int addr; bit tv; int idx; bit last; bit done;
    } vec_t;

    vec_t vt[13];

    task automatic run_u1_frame();
        fr1 = 1'b1;
        tick();
        fr1 = 1'b0;
        chk("u1_busy_c0", 144'(busy1), 144'(1));
        chk("u1_tv_c0", 144'(tv1), 144'(0));
        for (int c = 1; c <= 22; c++) begin
            tick();
            chk($sformatf("u1_tv_c%0d", c), 144'(tv1),
                144'(c >= 5 && c <= 20));
            if (c >= 5 && c <= 20) begin
                chk($sformatf("u1_data_c%0d", c), 144'(td1),
                    144'(pat1(c - 5)));
                chk($sformatf("u1_last_c%0d", c), 144'(tl1),
                    144'(c == 20));
            end
            if (c == 21) chk("u1_done", 144'(done1), 144'(1));
            if (c == 22) chk("u1_idle", 144'(busy1), 144'(0));
        end
    endtask

    task automatic collect0(input int nframes, input bit rnd,
                            input bit chk_start);
        int exp_idx = 0;
        int frames = 0;
        int dones = 0;
        int starts = 0;
        int cyc = 0;
        bit held = 1'b0;
        logic [143:0] hd = '0;
        logic hl = 1'b0;
        while (frames < nframes && cyc < 3000) begin
            if (held) begin
                chk("hold_valid", 144'(tv0), 144'(1));
                chk("hold_data", td0, hd);
                chk("hold_last", 144'(tl0), 144'(hl));
            end
            if (done0) dones++;
            if (chk_start && rd_en0 && rd_addr0 == 4'd0) begin
                starts++;
                if (starts > 1)
                    chk("start_after_done", 144'(dones), 144'(starts - 1));
            end
            tr0  = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            held = tv0 && !tr0;
            hd   = td0;
            hl   = tl0;
            if (tv0 && tr0) begin
                chk($sformatf("beat_data_%0d", exp_idx), td0, pat0(exp_idx));
                chk($sformatf("beat_last_%0d", exp_idx), 144'(tl0),
                    144'(exp_idx == 7));
                if (exp_idx == 7) frames++;
                exp_idx = (exp_idx + 1) % 8;
            end
            if (frames < nframes) tick();
            cyc++;
        end
        if (frames < nframes) begin
            n_cmp++;
            n_bad++;
            $display("FAIL collect_timeout: got %0d frames required %0d",
                     frames, nframes);
        end
        chk("done_count", 144'(dones), 144'(nframes - 1));
        tick();
        chk("frame_done", 144'(done0), 144'(1));
    endtask

    initial begin
        int nreads;
        vt[0]  = '{1'b1, 1'b0, -1, 1'b0, -1, 1'b0, 1'b0};
        vt[1]  = '{1'b1, 1'b1,  0, 1'b0, -1, 1'b0, 1'b0};
        vt[2]  = '{1'b1, 1'b1,  1, 1'b0, -1, 1'b0, 1'b0};
        vt[3]  = '{1'b1, 1'b1,  2, 1'b1,  0, 1'b0, 1'b0};
        vt[4]  = '{1'b1, 1'b1,  3, 1'b1,  1, 1'b0, 1'b0};
        vt[5]  = '{1'b1, 1'b1,  4, 1'b1,  2, 1'b0, 1'b0};
        vt[6]  = '{1'b1, 1'b1,  5, 1'b1,  3, 1'b0, 1'b0};
        vt[7]  = '{1'b1, 1'b1,  6, 1'b1,  4, 1'b0, 1'b0};
        vt[8]  = '{1'b1, 1'b1,  7, 1'b1,  5, 1'b0, 1'b0};
        vt[9]  = '{1'b1, 1'b0,  7, 1'b1,  6, 1'b0, 1'b0};
        vt[10] = '{1'b1, 1'b0,  7, 1'b1,  7, 1'b1, 1'b0};
        vt[11] = '{1'b1, 1'b0, -1, 1'b0, -1, 1'b0, 1'b1};
        vt[12] = '{1'b0, 1'b0,  0, 1'b0, -1, 1'b0, 1'b0};

        rst0 = 1'b0; rst1 = 1'b0;
        fr0 = 1'b0; fr1 = 1'b0; tr0 = 1'b1; tr1 = 1'b1;
        repeat (3) tick();
        chk("rst_rd_en", 144'(rd_en0), 144'(0));
        chk("rst_rd_addr", 144'(rd_addr0), 144'(0));
        chk("rst_tvalid", 144'(tv0), 144'(0));
        chk("rst_tlast", 144'(tl0), 144'(0));
        chk("rst_tdata", td0, 144'(0));
        chk("rst_busy", 144'(busy0), 144'(0));
        chk("rst_done", 144'(done0), 144'(0));
        chk("tstrb", 144'(ts0), 144'(18'h3FFFF));
        rst0 = 1'b1; rst1 = 1'b1;
        tick();

        // Short frame at full rate, cycle by cycle from the table
        fr0 = 1'b1;
        tick();
        fr0 = 1'b0;
        for (int i = 0; i < 13; i++) begin
            if (i > 0) tick();
            chk($sformatf("t1_busy_c%0d", i), 144'(busy0), 144'(vt[i].busy));
            chk($sformatf("t1_rden_c%0d", i), 144'(rd_en0), 144'(vt[i].rden));
            if (vt[i].addr >= 0)
                chk($sformatf("t1_addr_c%0d", i), 144'(rd_addr0),
                    144'(vt[i].addr));
            chk($sformatf("t1_tv_c%0d", i), 144'(tv0), 144'(vt[i].tv));
            if (vt[i].idx >= 0)
                chk($sformatf("t1_data_c%0d", i), td0, pat0(vt[i].idx));
            chk($sformatf("t1_last_c%0d", i), 144'(tl0), 144'(vt[i].last));
            chk($sformatf("t1_done_c%0d", i), 144'(done0), 144'(vt[i].done));
        end

        // Latency-3 instance: first beat 5 cycles after start, then 1/cycle
        run_u1_frame();

        // Downstream stalled from the start: reads stop at the FIFO depth
        tr0 = 1'b0;
        fr0 = 1'b1;
        tick();
        fr0 = 1'b0;
        nreads = 0;
        repeat (20) begin
            tick();
            if (rd_en0) nreads++;
        end
        chk("stall_reads", 144'(nreads), 144'(4));
        chk("stall_tvalid", 144'(tv0), 144'(1));
        chk("stall_data", td0, pat0(0));
        chk("stall_last", 144'(tl0), 144'(0));
        collect0(1, 1'b0, 1'b0);
        tick();
        chk("t4_idle", 144'(busy0), 144'(0));

        // frame_ready held high with random backpressure
        fr0 = 1'b1;
        collect0(3, 1'b1, 1'b1);
        fr0 = 1'b0;
        tick();
        chk("t6_idle", 144'(busy0), 144'(0));
        tick();
        chk("t6_no_restart", 144'(busy0), 144'(0));
        chk("t6_no_read", 144'(rd_en0), 144'(0));

        // Reset mid-frame on the latency-3 instance, then a clean frame
        fr1 = 1'b1;
        tick();
        fr1 = 1'b0;
        repeat (10) tick();
        chk("t5_mid_valid", 144'(tv1), 144'(1));
        chk("t5_mid_data", 144'(td1), 144'(pat1(5)));
        rst1 = 1'b0;
        #1;
        chk("t5_rst_rd_en", 144'(rd_en1), 144'(0));
        chk("t5_rst_addr", 144'(rd_addr1), 144'(0));
        chk("t5_rst_tvalid", 144'(tv1), 144'(0));
        chk("t5_rst_tlast", 144'(tl1), 144'(0));
        chk("t5_rst_tdata", 144'(td1), 144'(0));
        chk("t5_rst_busy", 144'(busy1), 144'(0));
        chk("t5_rst_done", 144'(done1), 144'(0));
        tick();
        chk("t5_rst_hold_tvalid", 144'(tv1), 144'(0));
        chk("t5_rst_hold_rd_en", 144'(rd_en1), 144'(0));
        rst1 = 1'b1;
        tick();
        run_u1_frame();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
